// File: rtl/alu_seq.sv
// Handshaked ALU: add/sub, logic, compares, and a one-bit-per-cycle serial shifter.
// Optional build macro ALU_SAT_EN makes ADD/SUB saturate on signed overflow.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_HOLD  = 2'b10;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_EQ   = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       shop_q, shop_d;

  logic             sub_s;
  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic [SHW-1:0]   shamt_s;
  logic             is_shift_s;
  logic [WIDTH-1:0] shift_step_s;
  logic             accept_s;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign out_valid = state_q[1];
  assign accept_s  = in_valid && in_ready;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

  assign shamt_s    = b[SHW-1:0];
  assign is_shift_s = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign sub_s      = (op == OP_SUB);
  assign b_op_s     = sub_s ? ~b : b;
  // SUB reuses the adder as a + ~b + 1 so carry means "no borrow".
  assign sum_s      = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, sub_s};

  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        if (sub_s) begin
          alu_v_s = (a[MSB] != b[MSB]) && (sum_s[MSB] != a[MSB]);
        end else begin
          alu_v_s = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
        end
`ifdef ALU_SAT_EN
        if (alu_v_s) begin
          alu_res_s = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          alu_res_s = sum_s[WIDTH-1:0];
        end
`endif
      end
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_NOT:  alu_res_s = ~a;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_EQ:   alu_res_s = {{(WIDTH-1){1'b0}}, (a == b)};
      // Shifts load the operand; the serial shifter does the rest.
      OP_SLL, OP_SRL, OP_SRA: alu_res_s = a;
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  always_comb begin
    shift_step_s = result_q;
    case (shop_q)
      2'b01:   shift_step_s = {result_q[WIDTH-2:0], 1'b0};
      2'b10:   shift_step_s = {1'b0, result_q[WIDTH-1:1]};
      2'b11:   shift_step_s = {result_q[MSB], result_q[WIDTH-1:1]};
      default: shift_step_s = result_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    cnt_d      = cnt_q;
    shop_d     = shop_q;
    if (accept_s) begin
      result_d   = alu_res_s;
      carry_d    = alu_c_s;
      overflow_d = alu_v_s;
      zero_d     = (alu_res_s == {WIDTH{1'b0}});
      negative_d = alu_res_s[MSB];
      shop_d     = op[1:0];
      if (is_shift_s && (shamt_s != {SHW{1'b0}})) begin
        state_d = S_SHIFT;
        cnt_d   = shamt_s;
      end else begin
        state_d = S_HOLD;
        cnt_d   = {SHW{1'b0}};
      end
    end else begin
      case (state_q)
        S_SHIFT: begin
          result_d   = shift_step_s;
          zero_d     = (shift_step_s == {WIDTH{1'b0}});
          negative_d = shift_step_s[MSB];
          cnt_d      = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_SHIFT;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      result_q   <= {WIDTH{1'b0}};
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      cnt_q      <= {SHW{1'b0}};
      shop_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      cnt_q      <= cnt_d;
      shop_q     <= shop_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed test-plan cases plus randomized
// streaming against an arithmetic reference model and an in-order scoreboard.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         carry, overflow, zero, negative;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;

  int n_vec = 0;
  int n_err = 0;
  logic [W+3:0] exp_q[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W+3:0] ref_alu(input logic [3:0] f_op, input logic [W-1:0] fa,
                                           input logic [W-1:0] fb);
    longint sa, sb, t, maxp, minn;
    logic [W-1:0] r;
    logic c, v;
    int k;
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    maxp = (longint'(1) <<< (W-1)) - 1;
    minn = -(longint'(1) <<< (W-1));
    k = int'(fb[4:0]);
    r = '0; c = 1'b0; v = 1'b0; t = 0;
    case (f_op)
      4'd0: begin
        t = sa + sb; r = fa + fb;
        c = (longint'({32'd0, fa}) + longint'({32'd0, fb})) > longint'({32'd0, {W{1'b1}}});
        v = (t > maxp) || (t < minn);
      end
      4'd1: begin
        t = sa - sb; r = fa - fb;
        c = (fa >= fb);
        v = (t > maxp) || (t < minn);
      end
      4'd2:  r = fa & fb;
      4'd3:  r = fa | fb;
      4'd4:  r = fa ^ fb;
      4'd5:  r = ~fa;
      4'd6:  r = ($signed(fa) < $signed(fb)) ? W'(1) : W'(0);
      4'd7:  r = (fa < fb) ? W'(1) : W'(0);
      4'd8:  r = (fa == fb) ? W'(1) : W'(0);
      4'd9:  r = fa << k;
      4'd10: r = fa >> k;
      4'd11: r = $signed(fa) >>> k;
      default: r = '0;
    endcase
`ifdef ALU_SAT_EN
    if (v) r = (t > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    return {r, c, v, (r == '0), r[W-1]};
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, measure latency, compare, then retire it.
  task automatic run_one(input string tag, input logic [3:0] f_op, input logic [W-1:0] fa,
                         input logic [W-1:0] fb, output logic [W+3:0] got);
    int lat, exp_lat;
    exp_lat = (f_op >= 4'd9 && f_op <= 4'd11 && fb[4:0] != 5'd0) ? int'(fb[4:0]) + 1 : 1;
    in_valid = 1'b1; op = f_op; a = fa; b = fb; out_ready = 1'b0;
    #1;
    check({tag, "_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      check({tag, "_busy"}, in_ready, 0);
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    got = {result, carry, overflow, zero, negative};
    check({tag, "_value"}, got, ref_alu(f_op, fa, fb));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic stream(input string tag, input int n_req, input bit b2b);
    int sent, cyc;
    sent = 0; cyc = 0;
    while ((sent < n_req || exp_q.size() != 0) && cyc < 20000) begin
      if (sent < n_req && (b2b || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        op = b2b ? 4'd0 : 4'($urandom_range(0, 15));
        a = rnd(); b = rnd();
      end else begin
        in_valid = 1'b0;
      end
      out_ready = b2b ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (b2b && sent < n_req) check({tag, "_ready"}, in_ready, 1);
      if (b2b && cyc >= 1 && cyc <= n_req) check({tag, "_valid"}, out_valid, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check({tag, "_spurious"}, 1, 0);
        else check({tag, "_out"}, {result, carry, overflow, zero, negative}, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_alu(op, a, b));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_sent"}, sent, n_req);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W+3:0] got, snap;
    bit ghost;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", {result, carry, overflow, zero, negative}, 0);
    rst = 1'b0;
    tick();

    run_one("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, got);
`ifdef ALU_SAT_EN
    check("add_ovf_explicit", got, {32'h7FFF_FFFF, 4'b0100});
`else
    check("add_ovf_explicit", got, {32'h8000_0000, 4'b0101});
`endif
    run_one("sub_eq", 4'd1, 32'd5, 32'd5, got);
    check("sub_eq_explicit", got, {32'h0, 4'b1010});
    run_one("sub_borrow", 4'd1, 32'd0, 32'd1, got);
    check("sub_borrow_explicit", got, {32'hFFFF_FFFF, 4'b0001});
    run_one("sra4", 4'd11, 32'h8000_0000, 32'd4, got);
    check("sra4_explicit", got[W+3:4], 32'hF800_0000);
    run_one("sll0", 4'd9, 32'h1234_5678, 32'hFFFF_FFE0, got);
    check("sll0_explicit", got[W+3:4], 32'h1234_5678);
    run_one("srl_hi_b", 4'd10, 32'hF000_000F, 32'hABCD_EF03, got);
    run_one("illegal13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, got);
    check("illegal13_explicit", got, {32'h0, 4'b0010});
    run_one("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, got);
    check("slt_explicit", got[W+3:4], 32'd1);
    run_one("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, got);
    check("sltu_explicit", got[W+3:4], 32'd0);

    // Backpressure: result must stay put and no new request may slip in.
    in_valid = 1'b1; op = 4'd0; a = 32'd10; b = 32'd20; out_ready = 1'b0;
    tick();
    op = 4'd4; a = 32'hDEAD_BEEF; b = 32'h1;
    check("bp_valid", out_valid, 1);
    snap = {result, carry, overflow, zero, negative};
    check("bp_value", snap, ref_alu(4'd0, 32'd10, 32'd20));
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready_low", in_ready, 0);
      tick();
      check("bp_stable", {result, carry, overflow, zero, negative}, snap);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_retired", out_valid, 0);

    // Reset in the middle of a long shift discards it.
    in_valid = 1'b1; op = 4'd9; a = 32'd1; b = 32'd31;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_state", {result, carry, overflow, zero, negative}, 0);
    check("midrst_ready", in_ready, 1);
    rst = 1'b0; out_ready = 1'b1;
    ghost = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) ghost = 1'b1;
    end
    out_ready = 1'b0;
    check("midrst_no_ghost", ghost, 0);

    stream("b2b", 8, 1'b1);
    stream("rand", 200, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
